uart_xmit_buf: RTL and testbench
================================

// Module: uart_xmit_buf
// PURPOSE
//  Buffered UART transmitter: the transmit-side counterpart of the receive data path in the uart top.
//  Accepts bytes from the host into a small FIFO and serialises them onto the line as 8N1 frames.
//  Frame format: start bit, 8 data bits LSB first, 1 stop bit.
//  Lets the host issue bursts of write strobes without waiting for each frame to finish.
// PARAMETERS
//  CLK_DIV     16  sys_clk cycles per bit period; must be >= 2.
//  FIFO_DEPTH  4   FIFO entries; must be a power of 2.
//  FIFO_AW     2   log2(FIFO_DEPTH).
// PORTS
//  sys_clk          in   1  sole clock; all logic on its rising edge.
//  sys_rst          in   1  synchronous, active-high reset.
//  xmitH            in   1  write strobe; one byte per cycle while high.
//  xmit_dataH       in   8  byte to transmit; sampled when xmitH=1.
//  xmit_fullH       out  1  FIFO holds FIFO_DEPTH entries.
//  xmit_emptyH      out  1  FIFO holds 0 entries (a frame may still be on the line).
//  xmit_busyH       out  1  FSM not in IDLE.
//  xmit_doneH       out  1  one-cycle pulse at the end of each stop bit.
//  xmit_ovfH        out  1  sticky: a write was dropped; cleared only by reset.
//  uart_XMIT_dataH  out  1  serial line, registered output, idle high.
// BEHAVIOUR
//  Reset (sys_rst=1 at an edge):
//   - FIFO emptied; FSM to IDLE; bit and baud counters cleared.
//   - Output values: uart_XMIT_dataH=1, xmit_emptyH=1, xmit_fullH=0, xmit_busyH=0, xmit_doneH=0, xmit_ovfH=0.
//   - Reset mid-frame aborts the frame: line is high after that edge, and no done pulse is generated.
//  FIFO:
//   - Write accepted when xmitH=1 and xmit_fullH=0 at the edge.
//   - A write with xmit_fullH=1 is dropped and sets xmit_ovfH. This holds even if a pop occurs in the same cycle.
//   - Pointers wrap modulo FIFO_DEPTH. Count is FIFO_AW+1 bits.
//   - Simultaneous push and pop leaves the count unchanged.
//   - Flags are registered and reflect the count after the edge.
//  FSM: IDLE -> START -> DATA -> STOP -> IDLE.
//   - IDLE: if the FIFO is non-empty at the edge, pop the head into the 8-bit shift register, clear baud_cnt, and go to START. Line = 1.
//   - START: line = 0 for CLK_DIV cycles, then go to DATA with bit_cnt=0.
//   - DATA: line = shift[0] for CLK_DIV cycles per bit; shift right after each bit. After bit_cnt=7, go to STOP.
//   - STOP: line = 1 for CLK_DIV cycles. On the last cycle, assert xmit_doneH for exactly that one cycle and go to IDLE.
//   - Baud counter runs 0..CLK_DIV-1; a state/bit advance happens when baud_cnt==CLK_DIV-1.
//  Timing:
//   - A write accepted at edge n into an empty, idle block is popped at edge n+1. Line goes low after edge n+1.
//   - Each frame is exactly 10*CLK_DIV cycles.
//   - Back-to-back frames are separated by exactly one IDLE cycle of line high.
//   - A host write landing in the same cycle as the IDLE pop is accepted normally.
// TESTING
//  T1 reset: drive sys_rst=1 for 2 cycles, with xmitH=1 during reset -> all outputs at reset values, no write captured.
//  T2 single byte: CLK_DIV=16, write 0xA5 at edge 0 ->
//     line low for cycles 1..16;
//     data bits 1,0,1,0,0,1,0,1, 16 cycles each;
//     stop high;
//     xmit_doneH pulses once on cycle 160; busy drops after it.
//  T3 burst: write 0x00,0xFF,0x3C on consecutive edges -> three frames in order, each 160 cycles, one idle cycle between frames, three done pulses, ovf=0.
//  T4 overflow: DEPTH=4, six consecutive writes 0x10..0x15 ->
//     0x10 is in the shifter and 0x11..0x14 are queued; xmit_fullH=1;
//     0x15 is dropped and xmit_ovfH=1 stays set;
//     the line carries exactly 0x10..0x14.
//  T5 reset mid-frame: assert sys_rst during data bit 3 of 0x81 with 2 bytes queued ->
//     line=1 on the next cycle, FIFO empty, no done pulse, no further frames.
//  T6 full+pop: FIFO full and a write in the same cycle as the IDLE pop -> write dropped, ovf set, count=FIFO_DEPTH-1 afterwards.

Source files
------------

// File: rtl/uart_xmit_buf.sv
// uart_xmit_buf: byte FIFO feeding an 8N1 serial transmitter with a registered line output
module uart_xmit_buf #(
  parameter int CLK_DIV    = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int FIFO_AW    = 2
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       xmitH,
  input  logic [7:0] xmit_dataH,
  output logic       xmit_fullH,
  output logic       xmit_emptyH,
  output logic       xmit_busyH,
  output logic       xmit_doneH,
  output logic       xmit_ovfH,
  output logic       uart_XMIT_dataH
);
  localparam int BW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  logic [7:0]         mem_q [FIFO_DEPTH];
  logic [FIFO_AW-1:0] wp_q, rp_q;
  logic [FIFO_AW:0]   cnt_q, cnt_d;
  logic               full_q, empty_q, ovf_q;
  logic [1:0]         st_q, st_d;
  logic [BW-1:0]      baud_q, baud_d;
  logic [2:0]         bit_q, bit_d;
  logic [7:0]         sh_q, sh_d;
  logic               line_q, line_d;
  logic               push, pop, tick;

  // A write is taken only when the FIFO was not full at this edge, even if a pop frees a slot now.
  assign push  = xmitH & ~full_q;
  assign pop   = (st_q == IDLE) & ~empty_q;
  assign tick  = baud_q == BW'(CLK_DIV - 1);
  assign cnt_d = cnt_q + (FIFO_AW+1)'(push) - (FIFO_AW+1)'(pop);

  assign xmit_fullH      = full_q;
  assign xmit_emptyH     = empty_q;
  assign xmit_ovfH       = ovf_q;
  assign xmit_busyH      = st_q != IDLE;
  assign xmit_doneH      = (st_q == STOP) & tick;
  assign uart_XMIT_dataH = line_q;

  // Frame sequencing; the line value is derived from the next state so the output register tracks it.
  always_comb begin
    st_d   = st_q;
    baud_d = tick ? '0 : baud_q + BW'(1);
    bit_d  = bit_q;
    sh_d   = sh_q;
    case (st_q)
      IDLE: begin
        baud_d = '0;
        if (pop) begin
          st_d = START;
          sh_d = mem_q[rp_q];
        end
      end
      START: if (tick) begin
        st_d  = DATA;
        bit_d = '0;
      end
      DATA: if (tick) begin
        sh_d  = {1'b0, sh_q[7:1]};
        bit_d = bit_q + 3'd1;
        st_d  = (bit_q == 3'd7) ? STOP : DATA;
      end
      default: st_d = tick ? IDLE : STOP;
    endcase
    line_d = (st_d == START) ? 1'b0 : (st_d == DATA) ? sh_d[0] : 1'b1;
  end

  // FIFO storage needs no reset; occupancy is tracked by the pointers and count.
  always_ff @(posedge sys_clk) begin
    if (push) mem_q[wp_q] <= xmit_dataH;
  end

  // FIFO bookkeeping, registered flags, and transmitter state.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      wp_q    <= '0;
      rp_q    <= '0;
      cnt_q   <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      ovf_q   <= 1'b0;
      st_q    <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      line_q  <= 1'b1;
    end else begin
      wp_q    <= push ? wp_q + FIFO_AW'(1) : wp_q;
      rp_q    <= pop ? rp_q + FIFO_AW'(1) : rp_q;
      cnt_q   <= cnt_d;
      full_q  <= cnt_d == (FIFO_AW+1)'(FIFO_DEPTH);
      empty_q <= cnt_d == '0;
      ovf_q   <= ovf_q | (xmitH & full_q);
      st_q    <= st_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      line_q  <= line_d;
    end
  end
endmodule

// File: tb/tb_uart_xmit_buf.sv
// tb_uart_xmit_buf: frame-decoding scoreboard bench for the buffered UART transmitter
module tb_uart_xmit_buf;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       xmit = 1'b0;
  logic [7:0] data = 8'h00;
  logic       full, empty, busy, done, ovf, line;

  uart_xmit_buf #(.CLK_DIV(16), .FIFO_DEPTH(4), .FIFO_AW(2)) dut (
    .sys_clk(clk), .sys_rst(rst), .xmitH(xmit), .xmit_dataH(data),
    .xmit_fullH(full), .xmit_emptyH(empty), .xmit_busyH(busy),
    .xmit_doneH(done), .xmit_ovfH(ovf), .uart_XMIT_dataH(line)
  );

  always #5 clk = ~clk;

  int         vec = 0;
  int         err = 0;
  int         cyc = 0;
  logic [7:0] sb [$];
  int         dq [$];

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    vec++;
    if (a !== e) begin
      err++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", n, a, e, cyc);
    end
  endtask

  task automatic wait_idle(input int lim);
    int k = 0;
    while (!(busy === 1'b0 && empty === 1'b1) && k < lim) begin
      @(negedge clk);
      k++;
    end
    chk("idle_timeout", k < lim, 1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Line monitor: decodes each frame at mid-bit and checks the done pulse lands on its last cycle.
  bit         in_fr = 0;
  int         off = 0;
  logic [7:0] rb;
  always @(negedge clk) begin
    cyc++;
    if (in_fr && busy === 1'b0) in_fr = 0;
    else if (in_fr) begin
      off++;
      if (off == 8) chk("start_bit", line, 0);
      if (off >= 24 && off <= 136 && (off - 24) % 16 == 0) rb[(off - 24) / 16] = line;
      if (off == 152) chk("stop_bit", line, 1);
      if (off == 159) begin
        chk("done_at_end", done, 1);
        if (sb.size() == 0) chk("unexpected_frame", {24'h0, rb}, 32'hffff_ffff);
        else chk("frame_byte", rb, sb.pop_front());
        dq.push_back(cyc);
        in_fr = 0;
      end else if (done === 1'b1) chk("early_done", done, 0);
    end else begin
      if (done === 1'b1) chk("idle_done", done, 0);
      if (line === 1'b0) begin
        in_fr = 1;
        off = 0;
      end
    end
  end

  typedef struct {
    logic       x;
    logic [7:0] d;
    bit         acc;
    logic       f, e, o, b;
  } vec_t;
  vec_t tv [8];

  initial begin
    tv[0] = '{1'b1, 8'h10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tv[1] = '{1'b1, 8'h11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    tv[2] = '{1'b1, 8'h12, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    tv[3] = '{1'b1, 8'h13, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    tv[4] = '{1'b1, 8'h14, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    tv[5] = '{1'b1, 8'h15, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    tv[6] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    tv[7] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

    // T1: reset held two cycles with a write strobe asserted
    @(negedge clk);
    rst = 1'b1; xmit = 1'b1; data = 8'h55;
    repeat (2) @(negedge clk);
    chk("rst_line", line, 1);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ovf", ovf, 0);
    rst = 1'b0; xmit = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_no_capture", {empty, busy, line}, 3'b101);

    // T2: single byte, cycle-exact start, done and busy-drop
    xmit = 1'b1; data = 8'hA5; sb.push_back(8'hA5);
    @(negedge clk);
    xmit = 1'b0;
    chk("t2_c0_line", line, 1);
    chk("t2_c0_empty", empty, 0);
    chk("t2_c0_busy", busy, 0);
    @(negedge clk);
    chk("t2_c1_line", line, 0);
    chk("t2_c1_busy", busy, 1);
    chk("t2_c1_empty", empty, 1);
    repeat (158) @(negedge clk);
    chk("t2_c159_done", done, 0);
    @(negedge clk);
    chk("t2_c160_done", done, 1);
    @(negedge clk);
    chk("t2_c161", {busy, done, line}, 3'b001);

    // T3: burst of three, frames 161 cycles apart (one idle cycle between)
    dq.delete();
    foreach (tv[i]) if (i < 3) begin
      data = (i == 0) ? 8'h00 : (i == 1) ? 8'hFF : 8'h3C;
      xmit = 1'b1; sb.push_back(data);
      @(negedge clk);
    end
    xmit = 1'b0;
    wait_idle(700);
    chk("t3_frames", dq.size(), 3);
    if (dq.size() == 3) begin
      chk("t3_gap1", dq[1] - dq[0], 161);
      chk("t3_gap2", dq[2] - dq[1], 161);
    end
    chk("t3_ovf", ovf, 0);

    // T4: overflow table
    for (int i = 0; i < 8; i++) begin
      xmit = tv[i].x; data = tv[i].d;
      if (tv[i].acc) sb.push_back(tv[i].d);
      @(negedge clk);
      chk($sformatf("t4_flags_%0d", i), {full, empty, ovf, busy}, {tv[i].f, tv[i].e, tv[i].o, tv[i].b});
    end
    xmit = 1'b0;
    wait_idle(1200);
    chk("t4_ovf_sticky", ovf, 1);
    chk("t4_sb_drained", sb.size(), 0);

    // T5: reset during data bit 3 of 0x81 with two bytes queued
    do_reset();
    foreach (tv[i]) if (i < 3) begin
      xmit = 1'b1; data = (i == 0) ? 8'h81 : (i == 1) ? 8'h11 : 8'h22;
      @(negedge clk);
    end
    xmit = 1'b0;
    repeat (68) @(negedge clk);
    chk("t5_mid_bit3", {busy, line}, 2'b10);
    rst = 1'b1;
    @(negedge clk);
    chk("t5_after_rst", {line, empty, busy, done, full, ovf}, 6'b110000);
    rst = 1'b0;
    begin
      int lows = 0, dones = 0;
      repeat (400) begin
        @(negedge clk);
        lows += (line !== 1'b1);
        dones += (done !== 1'b0);
      end
      chk("t5_no_frames", lows, 0);
      chk("t5_no_done", dones, 0);
    end

    // T6: FIFO full and a write in the same cycle as the idle pop
    foreach (tv[i]) if (i < 5) begin
      xmit = 1'b1; data = 8'h40 + 8'(i); sb.push_back(data);
      @(negedge clk);
    end
    xmit = 1'b0;
    chk("t6_full", full, 1);
    begin
      int k = 0;
      while (busy !== 1'b0 && k < 300) begin
        @(negedge clk);
        k++;
      end
      chk("t6_idle_timeout", k < 300, 1);
    end
    chk("t6_idle_full", {full, ovf}, 2'b10);
    xmit = 1'b1; data = 8'h77;
    @(negedge clk);
    xmit = 1'b0;
    chk("t6_after_pop", {full, empty, ovf, busy}, 4'b0011);
    wait_idle(800);
    chk("t6_sb_drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule
